fifo_read_ctrl: RTL
===================

# fifo_read_ctrl

Read-side pointer and status controller for the synchronous FIFO. It pairs with the write-address counter: it consumes `w_ptr`, owns the read pointer, and produces the memory read address, empty and almost-empty flags, occupancy, a registered read-data-valid strobe and an underflow strobe. It sits between the FIFO storage array and the consumer, in the same clock domain as the write side.

## Interface

Parameters:
- `MEMORY_DEPTH`, 4: number of FIFO entries; must equal 2^`FIFO_ADDRESS_SIZE`.
- `FIFO_ADDRESS_SIZE`, 2: storage address width.
- `ALMOST_EMPTY_LEVEL`, 1: `almost_empty` asserts when occupancy ≤ this value.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `rd_req`  input  1  consumer read request, sampled each cycle.
- `w_ptr`  input  `FIFO_ADDRESS_SIZE+1`  write pointer from the write-address counter; registered, same clock.
- `r_ptr`  output  `FIFO_ADDRESS_SIZE+1`  read pointer; the MSB is the wrap bit.
- `rd_addr`  output  `FIFO_ADDRESS_SIZE`  storage read address, equal to `r_ptr[FIFO_ADDRESS_SIZE-1:0]`.
- `rd_en`  output  1  storage read enable; combinational, `rd_req & ~empty`.
- `cr_max`  output  1  high when `rd_addr == MEMORY_DEPTH-1`, the last slot before the address wraps.
- `empty`  output  1  high when `r_ptr == w_ptr`.
- `almost_empty`  output  1  high when `count ≤ ALMOST_EMPTY_LEVEL`.
- `count`  output  `FIFO_ADDRESS_SIZE+1`  occupancy, `w_ptr - r_ptr` modulo 2^(`FIFO_ADDRESS_SIZE+1`).
- `rd_valid`  output  1  registered; high in the cycle after an accepted read, when storage data is valid.
- `underflow`  output  1  registered one-cycle pulse, set when `rd_req` arrives while `empty` is high.

## Operation

- **Accept rule:** a read is accepted in a cycle where `rd_req=1` and `empty=0`. In that cycle `rd_en=1` and the storage array is addressed by the current `rd_addr`.
- **Pointer update:** on an accepted read, `r_ptr <= r_ptr + 1`.
  - The pointer is `FIFO_ADDRESS_SIZE+1` bits wide and wraps naturally from 2·`MEMORY_DEPTH`-1 to 0.
  - The address bits wrap from `MEMORY_DEPTH-1` to 0 and toggle the wrap bit.
  - Otherwise `r_ptr` holds its value.
- **Flags:** `empty`, `almost_empty`, `count` and `cr_max` are combinational from `r_ptr` and `w_ptr`. No extra state is kept for them.
- **Full encoding:** a full FIFO has `count == MEMORY_DEPTH`, meaning the address bits are equal and the wrap bits differ. This block does not output a full flag, but `count` must report `MEMORY_DEPTH` correctly in that case.
- **Rejected read:** `rd_req` while `empty` is ignored. `r_ptr` does not move and `rd_en=0`. `underflow` pulses high in the following cycle.
- **`rd_valid`:** `rd_valid <= rd_req & ~empty`, a one-cycle registered copy of `rd_en`.
- **Simultaneous write and read:**
  - `w_ptr` advances while `r_ptr` advances. `count` is unchanged next cycle and `empty` does not assert.
  - If `empty` was high in the cycle of the write, the read is rejected. The data becomes readable in the next cycle.

## Timing

- **Reset:** with `rst=1` at a clock edge, after that edge `r_ptr=0`, `rd_valid=0` and `underflow=0`.
  - With `w_ptr=0`, this gives `empty=1`, `almost_empty=1`, `count=0`, `rd_addr=0`, `cr_max=0` (for `MEMORY_DEPTH>1`) and `rd_en=0`.
  - Reset overrides any concurrent `rd_req`.
- **Reset mid-operation:** pending `rd_valid` and `underflow` pulses are cleared at the reset edge. Reset has priority over every update.
- **Read latency:** request in cycle t, pointer advanced and `rd_valid=1` in cycle t+1, flags reflect the new pointer in cycle t+1.
- **Write-to-readable latency:** a write accepted in cycle t updates `w_ptr` at the t+1 edge. `empty` deasserts in cycle t+1, and a read may be accepted that same cycle.
- **Back-to-back reads:** one accepted read per cycle. With continuous `rd_req`, `rd_valid` stays high for exactly as many cycles as there were entries.
- **No combinational path from `rd_req` to `r_ptr`.** The only paths from `rd_req` are to `rd_en` and to the inputs of the registered outputs.

## Test plan

1. **Reset:** assert `rst` for 2 cycles with `rd_req=1` and `w_ptr=0` → `r_ptr=0`, `empty=1`, `count=0`, `rd_valid=0`, `underflow=0`, `rd_en=0`.
2. **Underflow:** `w_ptr=0`, pulse `rd_req` for 1 cycle → `r_ptr` stays 0, `rd_en=0`, `underflow=1` for exactly one cycle, `rd_valid=0`.
3. **Drain:** set `w_ptr=3`, hold `rd_req` for 4 cycles → `rd_addr` sequence 0,1,2; `rd_valid` high for 3 cycles; `count` goes 3,2,1,0; `almost_empty` rises when `count=1`; 4th request gives `underflow=1`.
4. **Wrap and full:** step `w_ptr` to 4 (full, `count=4`), then read 4 times → `cr_max=1` when `rd_addr=3`, `r_ptr` goes 0→4, `rd_addr` returns to 0. Continue with `w_ptr=7`, read 3 times → `r_ptr` reaches 7; with `w_ptr=0`, one more read wraps `r_ptr` to 0 and `empty=1`.
5. **Simultaneous:** `w_ptr=1`, `r_ptr=0`; in one cycle raise `rd_req` and advance `w_ptr` to 2 → next cycle `r_ptr=1`, `count=1`, `empty=0`, `rd_valid=1`.
6. **Reset mid-drain:** with `count=2` and a read accepted in the cycle before reset, assert `rst` → `r_ptr=0`, `rd_valid=0` after the reset edge.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_read_ctrl
//
// Read-side pointer and status controller for a single-clock FIFO. Owns the
// read pointer, consumes the write pointer from the write-address counter and
// derives the storage read address and status flags.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           synchronous, active-high reset
//   rd_req        consumer read request
//   w_ptr         write pointer (address bits plus wrap bit)
//   r_ptr         read pointer (address bits plus wrap bit)
//   rd_addr       storage read address
//   rd_en         storage read enable (rd_req & ~empty)
//   cr_max        read address sits on the last slot before wrapping
//   empty         read pointer equals write pointer
//   almost_empty  occupancy at or below ALMOST_EMPTY_LEVEL
//   count         occupancy, 0..MEMORY_DEPTH
//   rd_valid      registered, storage data valid the cycle after a read
//   underflow     registered one-cycle pulse after a read request on empty
// ---------------------------------------------------------------------------
module fifo_read_ctrl #(
    parameter int unsigned MEMORY_DEPTH       = 4,
    parameter int unsigned FIFO_ADDRESS_SIZE  = 2,
    parameter int unsigned ALMOST_EMPTY_LEVEL = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rd_req,
    input  logic [FIFO_ADDRESS_SIZE:0]   w_ptr,
    output logic [FIFO_ADDRESS_SIZE:0]   r_ptr,
    output logic [FIFO_ADDRESS_SIZE-1:0] rd_addr,
    output logic                         rd_en,
    output logic                         cr_max,
    output logic                         empty,
    output logic                         almost_empty,
    output logic [FIFO_ADDRESS_SIZE:0]   count,
    output logic                         rd_valid,
    output logic                         underflow
);

    localparam int unsigned AW = FIFO_ADDRESS_SIZE;
    localparam int unsigned PW = FIFO_ADDRESS_SIZE + 1;

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(MEMORY_DEPTH - 1);
    localparam logic [PW-1:0] AE_LEVEL  = PW'(ALMOST_EMPTY_LEVEL);

    logic [PW-1:0] r_ptr_q, r_ptr_d;
    logic          rd_valid_q, rd_valid_d;
    logic          underflow_q, underflow_d;

    logic          empty_w;
    logic          accept;

    // -----------------------------------------------------------------------
    // Status, purely combinational from the two pointers
    // -----------------------------------------------------------------------
    always_comb begin
        empty_w = (r_ptr_q == w_ptr);
        accept  = rd_req & ~empty_w;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        r_ptr_d     = r_ptr_q;
        rd_valid_d  = accept;
        underflow_d = rd_req & empty_w;
        if (accept) begin
            // Natural wrap of the full-width pointer toggles the wrap bit when
            // the address bits roll over.
            r_ptr_d = r_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_q     <= '0;
            rd_valid_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            r_ptr_q     <= r_ptr_d;
            rd_valid_q  <= rd_valid_d;
            underflow_q <= underflow_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        r_ptr        = r_ptr_q;
        rd_addr      = r_ptr_q[AW-1:0];
        rd_en        = accept;
        empty        = empty_w;
        // Modular difference gives MEMORY_DEPTH when full (address bits equal,
        // wrap bits differ) and 0 when empty.
        count        = w_ptr - r_ptr_q;
        almost_empty = (count <= AE_LEVEL);
        cr_max       = (r_ptr_q[AW-1:0] == ADDR_LAST);
        rd_valid     = rd_valid_q;
        underflow    = underflow_q;
    end

endmodule
